// File: rtl/mouse_bus_interface_pkg.sv
// -----------------------------------------------------------------------------
// mouse_bus_interface_pkg
// Shared constants and types for the mouse bus interface slice:
//   - register offsets within the BASE_ADDR window
//   - control register bit positions
//   - packet layout captured from the mouse transceiver
//   - default bus base address
//   - helper that formats the control/status byte
// -----------------------------------------------------------------------------
package mouse_bus_interface_pkg;

  localparam logic [7:0] DEFAULT_BASE_ADDR = 8'hA0;

  // Register offsets relative to BASE_ADDR.
  localparam logic [2:0] REG_STATUS = 3'd0;
  localparam logic [2:0] REG_X      = 3'd1;
  localparam logic [2:0] REG_Y      = 3'd2;
  localparam logic [2:0] REG_CTRL   = 3'd3;
  localparam logic [2:0] REG_POP    = 3'd4;

  // Bit positions in the control register write data.
  localparam int CTRL_IRQ_EN = 0;
  localparam int CTRL_FLUSH  = 1;

  // One mouse update: 4 status bits + 8-bit X + 8-bit Y.
  localparam int PKT_W = 20;

  typedef struct packed {
    logic [3:0] status;
    logic [7:0] x;
    logic [7:0] y;
  } mouse_pkt_t;

  // Control/status readback: {overflow, irq_en, 0, count[4:0]}.
  function automatic logic [7:0] ctrl_byte(input logic       overflow,
                                           input logic       irq_en,
                                           input logic [4:0] count);
    return {overflow, irq_en, 1'b0, count};
  endfunction

endpackage

// File: rtl/mouse_bus_interface_packet_fifo.sv
// -----------------------------------------------------------------------------
// packet_fifo
// Generic synchronous circular-buffer FIFO with a sticky overflow flag.
//   CLK, RESET     : clock, synchronous active-high reset
//   i_push, i_din  : write request and data
//   i_pop          : read request (advances head; ignored when empty)
//   i_flush        : empties the FIFO and clears overflow; beats push/pop
//   o_head         : entry at the read pointer (stale when o_empty)
//   o_full/o_empty : occupancy flags
//   o_count        : number of stored entries
//   o_overflow     : sticky, set when a push is dropped
//   o_push_ok      : a push was accepted this cycle
// -----------------------------------------------------------------------------
module packet_fifo #(
  parameter int WIDTH = 20,
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_flush,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_head,
  output logic             o_full,
  output logic             o_empty,
  output logic [PTR_W:0]   o_count,
  output logic             o_overflow,
  output logic             o_push_ok
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             r_overflow;

  logic w_do_push;
  logic w_do_pop;

  assign o_full  = (r_count == (PTR_W+1)'(DEPTH));
  assign o_empty = (r_count == '0);

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a
  // simultaneous push. A pop on an empty FIFO never happens.
  assign w_do_pop  = i_pop  && !o_empty && !i_flush;
  assign w_do_push = i_push && !i_flush && (!o_full || w_do_pop);

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else if (i_flush) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      // Pointers are PTR_W bits wide and DEPTH is a power of two, so the
      // increment wraps naturally.
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_do_push && !w_do_pop)      r_count <= r_count + 1'b1;
      else if (!w_do_push && w_do_pop) r_count <= r_count - 1'b1;
      if (i_push && !w_do_push)        r_overflow <= 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; occupancy is tracked by the
  // pointers/count, and the top masks head data while empty.
  always_ff @(posedge CLK) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_din;
  end

  assign o_head     = r_mem[r_rd_ptr];
  assign o_count    = r_count;
  assign o_overflow = r_overflow;
  assign o_push_ok  = w_do_push;

endmodule

// File: rtl/mouse_bus_interface.sv
// -----------------------------------------------------------------------------
// mouse_bus_interface
// Captures mouse transceiver updates into a packet FIFO and exposes them as
// memory-mapped registers on the shared 8-bit processor bus, with an
// interrupt raise/acknowledge handshake.
//   CLK, RESET             : clock, synchronous active-high reset
//   MOUSE_STATUS/X/Y       : transceiver outputs, sampled one cycle after the
//                            MOUSE_INTR rising edge
//   MOUSE_INTR             : update strobe (rising edge = one packet)
//   BUS_ADDR, BUS_WE       : processor address and write strobe
//   BUS_DATA               : bidirectional data, driven only for one cycle
//                            after a read of offsets +0..+3
//   BUS_INTERRUPT_RAISE    : interrupt request
//   BUS_INTERRUPT_ACK      : one-cycle acknowledge from the processor
// Register map (offset from BASE_ADDR):
//   +0 R {4'b0, status}   +1 R X   +2 R Y   (00 when FIFO empty)
//   +3 R {ovf, irq_en, 0, count}   +3 W bit0 irq_en, bit1 flush
//   +4 W pop head
// -----------------------------------------------------------------------------
module mouse_bus_interface
  import mouse_bus_interface_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR  = DEFAULT_BASE_ADDR,
  parameter int         FIFO_DEPTH = 4,
  parameter int         PTR_W      = 2
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [3:0] MOUSE_STATUS,
  input  logic [7:0] MOUSE_X,
  input  logic [7:0] MOUSE_Y,
  input  logic       MOUSE_INTR,
  input  logic [7:0] BUS_ADDR,
  inout  wire  [7:0] BUS_DATA,
  input  logic       BUS_WE,
  output logic       BUS_INTERRUPT_RAISE,
  input  logic       BUS_INTERRUPT_ACK
);

  // ---------------------------------------------------------------------------
  // Capture: the transceiver updates X/Y on the same edge that raises INTR,
  // so the rising edge only arms the push and data is sampled a cycle later.
  // ---------------------------------------------------------------------------
  logic r_prev_intr;
  logic r_push_pend;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_prev_intr <= 1'b0;
      r_push_pend <= 1'b0;
    end else begin
      r_prev_intr <= MOUSE_INTR;
      r_push_pend <= MOUSE_INTR && !r_prev_intr;
    end
  end

  // ---------------------------------------------------------------------------
  // Bus decode
  // ---------------------------------------------------------------------------
  logic [7:0] w_offset;
  logic       w_in_window;
  logic [2:0] w_reg;
  logic       w_wr_ctrl;
  logic       w_flush;
  logic       w_pop;

  assign w_offset    = BUS_ADDR - BASE_ADDR;
  assign w_in_window = (w_offset[7:3] == 5'd0);
  assign w_reg       = w_offset[2:0];
  assign w_wr_ctrl   = BUS_WE && w_in_window && (w_reg == REG_CTRL);
  assign w_flush     = w_wr_ctrl && BUS_DATA[CTRL_FLUSH];
  assign w_pop       = BUS_WE && w_in_window && (w_reg == REG_POP);

  // ---------------------------------------------------------------------------
  // Packet FIFO
  // ---------------------------------------------------------------------------
  mouse_pkt_t       w_din;
  logic [PKT_W-1:0] w_head_bits;
  mouse_pkt_t       w_head;
  logic             w_full;
  logic             w_empty;
  logic [PTR_W:0]   w_count;
  logic             w_overflow;
  logic             w_push_ok;

  assign w_din = '{status: MOUSE_STATUS, x: MOUSE_X, y: MOUSE_Y};

  packet_fifo #(
    .WIDTH (PKT_W),
    .DEPTH (FIFO_DEPTH),
    .PTR_W (PTR_W)
  ) u_fifo (
    .CLK        (CLK),
    .RESET      (RESET),
    .i_push     (r_push_pend),
    .i_pop      (w_pop),
    .i_flush    (w_flush),
    .i_din      (w_din),
    .o_head     (w_head_bits),
    .o_full     (w_full),
    .o_empty    (w_empty),
    .o_count    (w_count),
    .o_overflow (w_overflow),
    .o_push_ok  (w_push_ok)
  );

  assign w_head = mouse_pkt_t'(w_head_bits);

  // ---------------------------------------------------------------------------
  // Control register
  // ---------------------------------------------------------------------------
  logic r_irq_en;

  always_ff @(posedge CLK) begin
    if (RESET)          r_irq_en <= 1'b0;
    else if (w_wr_ctrl) r_irq_en <= BUS_DATA[CTRL_IRQ_EN];
  end

  // ---------------------------------------------------------------------------
  // Read path: data and output enable are registered at the address edge and
  // held for exactly one cycle.
  // ---------------------------------------------------------------------------
  logic       w_rd_hit;
  logic [7:0] w_rd_val;
  logic       r_oe;
  logic [7:0] r_rdata;

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    w_rd_hit = 1'b0;
    w_rd_val = 8'h00;
    if (!BUS_WE && w_in_window) begin
      case (w_reg)
        REG_STATUS: begin
          w_rd_hit = 1'b1;
          w_rd_val = w_empty ? 8'h00 : {4'b0000, w_head.status};
        end
        REG_X: begin
          w_rd_hit = 1'b1;
          w_rd_val = w_empty ? 8'h00 : w_head.x;
        end
        REG_Y: begin
          w_rd_hit = 1'b1;
          w_rd_val = w_empty ? 8'h00 : w_head.y;
        end
        REG_CTRL: begin
          w_rd_hit = 1'b1;
          w_rd_val = ctrl_byte(w_overflow, r_irq_en, 5'(w_count));
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_oe    <= 1'b0;
      r_rdata <= 8'h00;
    end else begin
      r_oe <= w_rd_hit;
      if (w_rd_hit) r_rdata <= w_rd_val;
    end
  end

  assign BUS_DATA = r_oe ? r_rdata : 8'bzzzz_zzzz;

  // ---------------------------------------------------------------------------
  // Interrupt: a new accepted packet raises (and beats a coincident ACK);
  // ACK or a disabled irq_en drops the request.
  // ---------------------------------------------------------------------------
  logic r_raise;

  always_ff @(posedge CLK) begin
    if (RESET)                                r_raise <= 1'b0;
    else if (w_push_ok && r_irq_en)           r_raise <= 1'b1;
    else if (BUS_INTERRUPT_ACK || !r_irq_en)  r_raise <= 1'b0;
  end

  assign BUS_INTERRUPT_RAISE = r_raise;

endmodule

// File: tb/tb_mouse_bus_interface.sv
// -----------------------------------------------------------------------------
// tb_mouse_bus_interface
// Directed bench for mouse_bus_interface. A cycle-level reference model
// (packet queue, overflow, irq_en, raise) is stepped once per clock edge with
// the stimulus the bench drove; expected bus read values are pushed onto a
// scoreboard queue when a read is issued and popped when the data appears.
// The bus carries a pullup, so a released bus reads 8'hFF.
// -----------------------------------------------------------------------------
module tb_mouse_bus_interface;

  localparam int         DEPTH = 4;
  localparam logic [7:0] BASE  = 8'hA0;
  localparam logic [7:0] IDLE_ADDR = 8'h00;
  localparam logic [7:0] RELEASED  = 8'hFF;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] mouse_status;
  logic [7:0] mouse_x;
  logic [7:0] mouse_y;
  logic       mouse_intr;
  logic [7:0] bus_addr;
  wire  [7:0] bus_data;
  logic       bus_we;
  logic       bus_raise;
  logic       bus_ack;
  logic       tb_drv_en;
  logic [7:0] tb_wdata;

  assign bus_data = tb_drv_en ? tb_wdata : 8'bzzzz_zzzz;
  pullup (bus_data);

  always #5 clk = ~clk;

  mouse_bus_interface #(
    .BASE_ADDR  (BASE),
    .FIFO_DEPTH (DEPTH),
    .PTR_W      (2)
  ) dut (
    .CLK                 (clk),
    .RESET               (reset),
    .MOUSE_STATUS        (mouse_status),
    .MOUSE_X             (mouse_x),
    .MOUSE_Y             (mouse_y),
    .MOUSE_INTR          (mouse_intr),
    .BUS_ADDR            (bus_addr),
    .BUS_DATA            (bus_data),
    .BUS_WE              (bus_we),
    .BUS_INTERRUPT_RAISE (bus_raise),
    .BUS_INTERRUPT_ACK   (bus_ack)
  );

  // Reference model state
  logic [19:0] m_q[$];
  logic        m_ovf;
  logic        m_irq_en;
  logic        m_raise;
  logic [7:0]  exp_q[$];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_raise(input string tag);
    check(tag, {7'b0, bus_raise}, {7'b0, m_raise});
  endtask

  function automatic void model_reset();
    m_q.delete();
    m_ovf    = 1'b0;
    m_irq_en = 1'b0;
    m_raise  = 1'b0;
  endfunction

  // One clock edge of the reference behaviour.
  function automatic void model_edge(input bit push, input logic [19:0] pkt,
                                     input bit pop, input bit wr_ctrl,
                                     input logic [7:0] cdata, input bit ack);
    bit old_irq = m_irq_en;
    bit push_ok = 1'b0;
    if (wr_ctrl && cdata[1]) begin
      m_q.delete();
      m_ovf = 1'b0;
    end else begin
      if (pop && m_q.size() > 0) void'(m_q.pop_front());
      if (push) begin
        if (m_q.size() < DEPTH) begin
          m_q.push_back(pkt);
          push_ok = 1'b1;
        end else begin
          m_ovf = 1'b1;
        end
      end
    end
    if (wr_ctrl) m_irq_en = cdata[0];
    if (push_ok && old_irq)   m_raise = 1'b1;
    else if (ack || !old_irq) m_raise = 1'b0;
  endfunction

  function automatic logic [7:0] exp_read(input logic [7:0] addr);
    logic [7:0]  off = addr - BASE;
    logic [19:0] h;
    if (off == 8'd3) return {m_ovf, m_irq_en, 1'b0, 5'(m_q.size())};
    if (off > 8'd2)  return RELEASED;
    if (m_q.size() == 0) return 8'h00;
    h = m_q[0];
    case (off)
      8'd0:    return {4'b0, h[19:16]};
      8'd1:    return h[15:8];
      default: return h[7:0];
    endcase
  endfunction

  task automatic idle_cycle();
    @(negedge clk);
    model_edge(1'b0, '0, 1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic bus_write(input logic [7:0] addr, input logic [7:0] data);
    bus_addr  = addr;
    bus_we    = 1'b1;
    tb_wdata  = data;
    tb_drv_en = 1'b1;
    @(negedge clk);
    model_edge(1'b0, '0, addr == BASE + 8'd4, addr == BASE + 8'd3, data, 1'b0);
    bus_we    = 1'b0;
    tb_drv_en = 1'b0;
    bus_addr  = IDLE_ADDR;
  endtask

  // Read: expectation queued at issue, compared when data is on the bus;
  // a trailing idle cycle lets the bus release before the next access.
  task automatic bus_read(input string tag, input logic [7:0] addr);
    logic [7:0] exp;
    exp_q.push_back(exp_read(addr));
    bus_addr = addr;
    bus_we   = 1'b0;
    @(negedge clk);
    model_edge(1'b0, '0, 1'b0, 1'b0, 8'h00, 1'b0);
    exp = exp_q.pop_front();
    check(tag, bus_data, exp);
    bus_addr = IDLE_ADDR;
    idle_cycle();
  endtask

  task automatic ack_pulse(input string tag);
    bus_ack = 1'b1;
    @(negedge clk);
    model_edge(1'b0, '0, 1'b0, 1'b0, 8'h00, 1'b1);
    bus_ack = 1'b0;
    check_raise(tag);
  endtask

  // One INTR pulse; optional pop / control write / ACK on the push cycle.
  task automatic mouse_update(input string tag, input logic [19:0] pkt,
                              input bit pop, input bit wr_ctrl,
                              input logic [7:0] cdata, input bit ack);
    {mouse_status, mouse_x, mouse_y} = pkt;
    mouse_intr = 1'b1;
    @(negedge clk);
    model_edge(1'b0, '0, 1'b0, 1'b0, 8'h00, 1'b0);
    check_raise({tag, "_raise_armed"});
    mouse_intr = 1'b0;
    if (pop) begin
      bus_addr = BASE + 8'd4; bus_we = 1'b1; tb_wdata = 8'h00; tb_drv_en = 1'b1;
    end else if (wr_ctrl) begin
      bus_addr = BASE + 8'd3; bus_we = 1'b1; tb_wdata = cdata; tb_drv_en = 1'b1;
    end
    bus_ack = ack;
    @(negedge clk);
    model_edge(1'b1, pkt, pop, wr_ctrl, cdata, ack);
    bus_we = 1'b0; tb_drv_en = 1'b0; bus_addr = IDLE_ADDR; bus_ack = 1'b0;
    check_raise({tag, "_raise_push"});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; mouse_status = '0; mouse_x = '0; mouse_y = '0; mouse_intr = 1'b0;
    bus_addr = IDLE_ADDR; bus_we = 1'b0; bus_ack = 1'b0; tb_drv_en = 1'b0; tb_wdata = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_raise("reset_raise");
    check("reset_bus_hiz", bus_data, RELEASED);
    reset = 1'b0;
    bus_read("reset_ctrl", BASE + 8'd3);
    bus_read("reset_status", BASE);

    // Single packet with interrupts enabled
    bus_write(BASE + 8'd3, 8'h01);
    mouse_update("p1", {4'h9, 8'h50, 8'h3C}, 0, 0, 8'h00, 0);
    bus_read("p1_status", BASE);
    bus_read("p1_x", BASE + 8'd1);
    bus_read("p1_y", BASE + 8'd2);
    bus_read("p1_ctrl", BASE + 8'd3);
    ack_pulse("ack_alone");

    // Overflow: four more pushes into a depth-4 FIFO, the last is lost
    mouse_update("p2", {4'h1, 8'h11, 8'h21}, 0, 0, 8'h00, 0);
    mouse_update("p3", {4'h2, 8'h22, 8'h32}, 0, 0, 8'h00, 0);
    mouse_update("p4", {4'h3, 8'h33, 8'h43}, 0, 0, 8'h00, 0);
    mouse_update("p5", {4'h4, 8'h44, 8'h54}, 0, 0, 8'h00, 0);
    bus_read("ovf_ctrl", BASE + 8'd3);
    bus_read("ovf_head_status", BASE);
    bus_read("ovf_head_x", BASE + 8'd1);

    // Pop down to two, then pop and push together
    bus_write(BASE + 8'd4, 8'h00);
    bus_write(BASE + 8'd4, 8'h00);
    bus_read("pop2_ctrl", BASE + 8'd3);
    bus_read("pop2_head_x", BASE + 8'd1);
    mouse_update("p6_pop", {4'h5, 8'h55, 8'h65}, 1, 0, 8'h00, 0);
    bus_read("pushpop_ctrl", BASE + 8'd3);
    bus_read("pushpop_head_x", BASE + 8'd1);
    bus_write(BASE + 8'd4, 8'h00);
    bus_read("wrap_head_x", BASE + 8'd1);
    bus_read("wrap_head_y", BASE + 8'd2);
    bus_write(BASE + 8'd4, 8'h00);
    bus_read("empty_x", BASE + 8'd1);
    bus_write(BASE + 8'd4, 8'h00);
    bus_read("pop_empty_ctrl", BASE + 8'd3);

    // ACK on the push cycle loses to the push
    mouse_update("p7_ack", {4'h6, 8'h66, 8'h76}, 0, 0, 8'h00, 1);
    ack_pulse("ack_after");

    // Disabling irq_en drops RAISE; re-enabling with data queued does not raise
    mouse_update("p8", {4'h7, 8'h77, 8'h07}, 0, 0, 8'h00, 0);
    bus_write(BASE + 8'd3, 8'h00);
    idle_cycle();
    check_raise("irq_dis_clears");
    bus_write(BASE + 8'd3, 8'h01);
    idle_cycle();
    idle_cycle();
    check_raise("irq_en_no_raise");

    // Flush on the push cycle discards the packet
    mouse_update("p9_flush", {4'h8, 8'h88, 8'h98}, 0, 1, 8'h03, 0);
    bus_read("flush_push_ctrl", BASE + 8'd3);

    // Full FIFO with simultaneous pop and push: no overflow
    mouse_update("p10", {4'hA, 8'h0A, 8'h1A}, 0, 0, 8'h00, 0);
    mouse_update("p11", {4'hB, 8'h0B, 8'h1B}, 0, 0, 8'h00, 0);
    mouse_update("p12", {4'hC, 8'h0C, 8'h1C}, 0, 0, 8'h00, 0);
    mouse_update("p13", {4'hD, 8'h0D, 8'h1D}, 0, 0, 8'h00, 0);
    ack_pulse("ack_full");
    mouse_update("p14_pop", {4'hE, 8'h0E, 8'h1E}, 1, 0, 8'h00, 0);
    bus_read("full_pushpop_ctrl", BASE + 8'd3);
    bus_read("full_pushpop_head_y", BASE + 8'd2);

    // INTR held high for ten cycles gives one packet
    bus_write(BASE + 8'd3, 8'h03);
    bus_read("flush_ctrl", BASE + 8'd3);
    {mouse_status, mouse_x, mouse_y} = {4'h2, 8'h5A, 8'h6B};
    mouse_intr = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      model_edge(i == 1, {4'h2, 8'h5A, 8'h6B}, 1'b0, 1'b0, 8'h00, 1'b0);
    end
    mouse_intr = 1'b0;
    idle_cycle();
    bus_read("held_intr_ctrl", BASE + 8'd3);
    bus_write(BASE + 8'd3, 8'h02);
    bus_read("flush2_ctrl", BASE + 8'd3);
    bus_read("flush2_status", BASE);

    // Reset in the middle of a read
    bus_write(BASE + 8'd3, 8'h01);
    mouse_update("p16", {4'h3, 8'h4D, 8'h2E}, 0, 0, 8'h00, 0);
    exp_q.push_back(exp_read(BASE + 8'd1));
    bus_addr = BASE + 8'd1;
    @(negedge clk);
    model_edge(1'b0, '0, 1'b0, 1'b0, 8'h00, 1'b0);
    check("midread_data", bus_data, exp_q.pop_front());
    reset = 1'b1;
    @(negedge clk);
    model_reset();
    check("midread_reset_hiz", bus_data, RELEASED);
    reset = 1'b0;
    bus_addr = IDLE_ADDR;
    idle_cycle();
    check_raise("post_reset_raise");
    bus_read("post_reset_ctrl", BASE + 8'd3);

    // Addresses outside the read map leave the bus released
    bus_read("addr_a5", BASE + 8'd5);
    check("addr_a5_after", bus_data, RELEASED);
    bus_read("addr_a4_read", BASE + 8'd4);
    bus_read("addr_9f", BASE - 8'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
